// File: rtl/snake_game_score_and_timer.sv
// Score counter and per-game countdown feeding the master state machine.
// Play_State gates everything: IDLE reloads, PLAY counts, WIN/LOSE/unknown freeze.
module snake_game_score_and_timer #(
  parameter int TICKS_PER_SEC = 100000000,
  parameter int PLAY_TIME_S   = 60,
  parameter int SCORE_MAX     = 15
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] Play_State,
  input  logic       Target_Reached,
  output logic [3:0] Score,
  output logic       Score_Tick,
  output logic [7:0] Time_Left,
  output logic       time_is_up
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  localparam logic [1:0]    ST_IDLE    = 2'b00;
  localparam logic [1:0]    ST_PLAY    = 2'b01;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [7:0]    TIME_INIT  = 8'(PLAY_TIME_S);
  localparam logic [3:0]    SCORE_TOP  = 4'(SCORE_MAX);

  logic [3:0]    score_q, score_d;
  logic          score_tick_q, score_tick_d;
  logic [7:0]    time_left_q, time_left_d;
  logic          time_is_up_q, time_is_up_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tr_q, tr_d;
  logic          hit;
  logic          sec_tick;

  assign hit      = Target_Reached & ~tr_q;
  assign sec_tick = (presc_q == PRESC_LAST);

  always_comb begin
    score_d      = score_q;
    score_tick_d = 1'b0;
    time_left_d  = time_left_q;
    time_is_up_d = time_is_up_q;
    presc_d      = presc_q;
    // Edge register tracks in every mode so a level held across IDLE->PLAY never scores.
    tr_d         = Target_Reached;

    case (Play_State)
      ST_IDLE: begin
        score_d      = 4'd0;
        time_left_d  = TIME_INIT;
        time_is_up_d = 1'b0;
        presc_d      = '0;
      end
      ST_PLAY: begin
        presc_d = sec_tick ? '0 : presc_q + 1'b1;
        if (hit && (score_q < SCORE_TOP)) begin
          score_d      = score_q + 4'd1;
          score_tick_d = 1'b1;
        end
        if (sec_tick && (time_left_q != 8'd0)) begin
          time_left_d = time_left_q - 8'd1;
          if (time_left_q == 8'd1) time_is_up_d = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      score_q      <= 4'd0;
      score_tick_q <= 1'b0;
      time_left_q  <= TIME_INIT;
      time_is_up_q <= 1'b0;
      presc_q      <= '0;
      tr_q         <= 1'b0;
    end else begin
      score_q      <= score_d;
      score_tick_q <= score_tick_d;
      time_left_q  <= time_left_d;
      time_is_up_q <= time_is_up_d;
      presc_q      <= presc_d;
      tr_q         <= tr_d;
    end
  end

  assign Score      = score_q;
  assign Score_Tick = score_tick_q;
  assign Time_Left  = time_left_q;
  assign time_is_up = time_is_up_q;

endmodule
